fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction-memory fetches for the 5-stage MIPS pipeline.
//  Drives the combinational instruction ROM address, registers the returned word into the IF/ID latch,
//  and applies stalls, branch/jump redirects, exceptions and timer interrupts.
//  PC[31] is the kernel bit; interrupts are taken only in user mode.
//  Sits between the hazard/branch logic in ID/EX and the instruction ROM.
// PARAMETERS
//  RESET_VEC  32'h8000_0000  PC after reset (kernel mode)
//  IRQ_VEC    32'h8000_0004  interrupt entry
//  EXC_VEC    32'h8000_0008  exception entry
// PORTS
//  clk             in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-high
//  imem_addr       out  32  ROM address; equals pc combinationally
//  imem_instr      in   32  ROM data for imem_addr, same cycle
//  stall           in   1   hazard unit: hold PC and IF/ID
//  redirect_valid  in   1   taken branch / j / jal / jr resolved this cycle
//  redirect_pc     in   32  target; all 32 bits loaded, including bit 31
//  exc             in   1   exception raised by a later stage (undefined opcode)
//  exc_pc          in   32  return address for the exception
//  irq             in   1   timer interrupt request, level, synchronous to clk
//  ifid_instr      out  32  latched instruction
//  ifid_pc4        out  32  latched PC+4 of that instruction
//  ifid_valid      out  1   0 = bubble; ID must treat ifid_instr as nop
//  epc             out  32  return address captured at IRQ or exception entry
//  epc_we          out  1   one-cycle pulse: datapath writes epc into $k0 ($26)
//  fetch_cnt       out  32  count of valid instructions delivered to IF/ID; wraps
// BEHAVIOUR
//  Reset (async):
//   - pc=RESET_VEC; ifid_instr=0; ifid_pc4=0; ifid_valid=0.
//   - epc=0; epc_we=0; fetch_cnt=0; irq_pend=0; irq_q=0.
//  irq_q <= irq each cycle.
//  irq_pend sets on an irq rising edge (irq & !irq_q).
//  irq_pend clears only when the interrupt is taken; edges while pending are absorbed.
//  Per rising edge, highest priority first (exactly one branch applies):
//   1 exc:
//     - pc<=EXC_VEC; ifid_valid<=0; epc<=exc_pc; epc_we<=1.
//     - Overrides stall and redirect.
//   2 redirect_valid:
//     - pc<=redirect_pc; ifid_valid<=0 (one-bubble squash of the wrong-path fetch).
//     - Overrides stall.
//   3 stall:
//     - pc, ifid_* and fetch_cnt hold. irq_pend still sets.
//   4 irq_pend & !pc[31]:
//     - pc<=IRQ_VEC; epc<=pc (the unfetched instruction is the return point); epc_we<=1.
//     - ifid_valid<=0; irq_pend<=0.
//   5 normal fetch:
//     - pc<={pc[31], pc[30:0]+4}; ifid_instr<=imem_instr; ifid_pc4<={pc[31], pc[30:0]+4}.
//     - ifid_valid<=1; fetch_cnt<=fetch_cnt+1.
//  epc_we is 0 in every cycle not covered by branch 1 or branch 4.
//  Arithmetic: the PC increment is modulo 2^31 in bits 30:0; bit 31 is never altered by increment.
//  Latency: imem_addr=X at edge N gives ifid_instr=ROM[X] after edge N+1 if unstalled; redirect costs 1 bubble.
//  Kernel mode: while pc[31]=1, irq_pend stays set and the interrupt is taken on the first user-mode fetch.
//   - Example: jr $26 loads redirect_pc with bit 31 = 0; the next unstalled cycle takes the pending IRQ.
//  Reset mid-operation: all state returns to reset values immediately; pending IRQ is lost.
// TESTING
//  T1 reset:
//     release reset -> imem_addr 80000000; edge 1 gives ifid_valid=1, ifid_pc4=80000004; fetch_cnt=1.
//  T2 stall:
//     stall=1 for 3 cycles at pc=8000000C -> pc, ifid_* and fetch_cnt frozen; resume fetches 8000000C.
//  T3 redirect:
//     redirect_valid with redirect_pc=00400068 -> next cycle ifid_valid=0, imem_addr=00400068.
//     Asserted with stall=1, the redirect still wins.
//  T4 irq in user mode:
//     pc=00400010, irq rise -> next edge pc=80000004, epc=00400010, epc_we pulse, ifid_valid=0.
//  T5 irq in kernel mode:
//     irq rise at pc=8000002C -> no entry; after redirect to 00400020, next edge pc=80000004, epc=00400020.
//  T6 simultaneous exc+redirect+irq_pend:
//     exc_pc=00400044 -> pc=80000008, epc=00400044, irq_pend still 1.
//     Async reset mid-stall -> all outputs to reset values.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Bundles the fetch sequencer's ROM, control-input and IF/ID-output signals.
// The master side is the sequencer; the slave side is the surrounding pipeline.
interface fetch_sequencer_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc;
    logic [31:0] exc_pc;
    logic        irq;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] epc;
    logic        epc_we;
    logic [31:0] fetch_cnt;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  exc,
        input  exc_pc,
        input  irq,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid,
        output epc,
        output epc_we,
        output fetch_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output redirect_valid,
        output redirect_pc,
        output exc,
        output exc_pc,
        output irq,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid,
        input  epc,
        input  epc_we,
        input  fetch_cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and IF stage: drives the instruction ROM and fills the IF/ID latch,
// arbitrating exceptions, redirects, stalls and user-mode timer interrupts.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ACT_FETCH,
        ACT_EXC,
        ACT_REDIR,
        ACT_STALL,
        ACT_IRQ
    } action_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    logic [31:0] pc, pc_n;
    ifid_t       ifid, ifid_n;
    logic [31:0] epc, epc_n;
    logic        epc_we, epc_we_n;
    logic [31:0] fetch_cnt, fetch_cnt_n;
    logic        irq_pend, irq_pend_n;
    logic        irq_q;
    logic        irq_rise;
    logic [31:0] pc_seq;
    action_e     action;

    // Bit 31 is the kernel bit and is never carried into by the increment.
    assign pc_seq   = {pc[31], pc[30:0] + 31'd4};
    assign irq_rise = bus.irq & ~irq_q;

    always_comb begin
        action = ACT_FETCH;
        if (bus.exc)
            action = ACT_EXC;
        else if (bus.redirect_valid)
            action = ACT_REDIR;
        else if (bus.stall)
            action = ACT_STALL;
        else if (irq_pend && !pc[31])
            action = ACT_IRQ;
    end

    always_comb begin
        pc_n        = pc;
        ifid_n      = ifid;
        epc_n       = epc;
        epc_we_n    = 1'b0;
        fetch_cnt_n = fetch_cnt;
        // Edges arriving while already pending are absorbed by the OR.
        irq_pend_n  = irq_pend | irq_rise;
        case (action)
            ACT_EXC: begin
                pc_n         = EXC_VEC;
                ifid_n.valid = 1'b0;
                epc_n        = bus.exc_pc;
                epc_we_n     = 1'b1;
            end
            ACT_REDIR: begin
                pc_n         = bus.redirect_pc;
                ifid_n.valid = 1'b0;
            end
            ACT_STALL: begin
            end
            ACT_IRQ: begin
                // The instruction at pc was never delivered, so it is the return point.
                pc_n         = IRQ_VEC;
                ifid_n.valid = 1'b0;
                epc_n        = pc;
                epc_we_n     = 1'b1;
                irq_pend_n   = 1'b0;
            end
            ACT_FETCH: begin
                pc_n         = pc_seq;
                ifid_n.instr = bus.imem_instr;
                ifid_n.pc4   = pc_seq;
                ifid_n.valid = 1'b1;
                fetch_cnt_n  = fetch_cnt + 32'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_VEC;
            ifid      <= '0;
            epc       <= '0;
            epc_we    <= 1'b0;
            fetch_cnt <= '0;
            irq_pend  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            pc        <= pc_n;
            ifid      <= ifid_n;
            epc       <= epc_n;
            epc_we    <= epc_we_n;
            fetch_cnt <= fetch_cnt_n;
            irq_pend  <= irq_pend_n;
            irq_q     <= bus.irq;
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.ifid_instr = ifid.instr;
    assign bus.ifid_pc4   = ifid.pc4;
    assign bus.ifid_valid = ifid.valid;
    assign bus.epc        = epc;
    assign bus.epc_we     = epc_we;
    assign bus.fetch_cnt  = fetch_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus randomized traffic for fetch_sequencer, checked each
// cycle against a priority-rule reference model of the architectural state.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_instr = rom_word(bus.imem_addr);

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_epc, m_cnt;
    logic        m_valid, m_epc_we, m_pend, m_irq_prev;

    function automatic void model_reset();
        m_pc = 32'h8000_0000; m_instr = 0; m_pc4 = 0; m_valid = 0;
        m_epc = 0; m_epc_we = 0; m_cnt = 0; m_pend = 0; m_irq_prev = 0;
    endfunction

    function automatic void model_step(input logic st, input logic rv, input logic [31:0] rp,
                                       input logic ex, input logic [31:0] ep, input logic iq);
        logic [31:0] next_seq;
        logic        taken;
        next_seq = {m_pc[31], 31'(m_pc[30:0] + 31'd4)};
        taken    = 0;
        m_epc_we = 0;
        if (ex) begin
            m_pc = 32'h8000_0008; m_valid = 0; m_epc = ep; m_epc_we = 1;
        end else if (rv) begin
            m_pc = rp; m_valid = 0;
        end else if (st) begin
            // everything visible holds
        end else if (m_pend && m_pc[31] == 1'b0) begin
            m_epc = m_pc; m_epc_we = 1; m_pc = 32'h8000_0004; m_valid = 0; taken = 1;
        end else begin
            m_instr = rom_word(m_pc); m_pc4 = next_seq; m_pc = next_seq;
            m_valid = 1; m_cnt = m_cnt + 1;
        end
        if (taken) m_pend = 0;
        else if (iq && !m_irq_prev) m_pend = 1;
        m_irq_prev = iq;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr",  bus.imem_addr,  m_pc);
        chk("ifid_instr", bus.ifid_instr, m_instr);
        chk("ifid_pc4",   bus.ifid_pc4,   m_pc4);
        chk("ifid_valid", 32'(bus.ifid_valid), 32'(m_valid));
        chk("epc",        bus.epc,        m_epc);
        chk("epc_we",     32'(bus.epc_we), 32'(m_epc_we));
        chk("fetch_cnt",  bus.fetch_cnt,  m_cnt);
        chk("irq_pend",   32'(dut.irq_pend), 32'(m_pend));
    endtask

    // Drive one cycle from a negedge, advance the model, compare at the next negedge.
    task automatic cyc(input logic st, input logic rv, input logic [31:0] rp,
                       input logic ex, input logic [31:0] ep, input logic iq);
        bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rp;
        bus.exc = ex; bus.exc_pc = ep; bus.irq = iq;
        model_step(st, rv, rp, ex, ep, iq);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Asserts reset 2 time units after a negedge, i.e. away from any clock edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_addr",  bus.imem_addr, 32'h8000_0000);
        chk("rst_valid", 32'(bus.ifid_valid), 32'd0);
        chk("rst_cnt",   bus.fetch_cnt, 32'd0);
        @(negedge clk);
        bus.irq = 1'b0;
        reset = 1'b0;
    endtask

    logic        r_st, r_rv, r_ex, r_iq;
    logic [31:0] r_rp, r_ep;

    initial begin
        reset = 1'b1;
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.exc = 0; bus.exc_pc = 0; bus.irq = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("t1_reset_addr", bus.imem_addr, 32'h8000_0000);
        reset = 1'b0;

        // T1: first fetch after reset
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1_valid", 32'(bus.ifid_valid), 32'd1);
        chk("t1_pc4",   bus.ifid_pc4, 32'h8000_0004);
        chk("t1_cnt",   bus.fetch_cnt, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // T2: stall at 8000000C
        chk("t2_pc_pre", bus.imem_addr, 32'h8000_000C);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        chk("t2_pc_hold",  bus.imem_addr, 32'h8000_000C);
        chk("t2_cnt_hold", bus.fetch_cnt, 32'd3);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t2_resume_pc4", bus.ifid_pc4, 32'h8000_0010);
        chk("t2_resume_ins", bus.ifid_instr, rom_word(32'h8000_000C));

        // T3: redirect, then redirect under stall
        cyc(0, 1, 32'h0040_0068, 0, 0, 0);
        chk("t3_valid", 32'(bus.ifid_valid), 32'd0);
        chk("t3_addr",  bus.imem_addr, 32'h0040_0068);
        cyc(1, 1, 32'h0040_0010, 0, 0, 0);
        chk("t3_stall_redir", bus.imem_addr, 32'h0040_0010);

        // T4: user-mode irq; pending latched during a stall, taken next cycle
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t4_pc",     bus.imem_addr, 32'h8000_0004);
        chk("t4_epc",    bus.epc, 32'h0040_0010);
        chk("t4_epc_we", 32'(bus.epc_we), 32'd1);
        chk("t4_valid",  32'(bus.ifid_valid), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_we_pulse", 32'(bus.epc_we), 32'd0);

        // T5: irq in kernel mode waits for the return to user mode
        cyc(0, 1, 32'h8000_002C, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t5_no_entry", bus.imem_addr, 32'h8000_0034);
        cyc(0, 1, 32'h0040_0020, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t5_pc",  bus.imem_addr, 32'h8000_0004);
        chk("t5_epc", bus.epc, 32'h0040_0020);

        // T6: exc beats redirect and a pending irq; pending survives
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 32'h0040_0200, 1, 32'h0040_0044, 1);
        chk("t6_pc",   bus.imem_addr, 32'h8000_0008);
        chk("t6_epc",  bus.epc, 32'h0040_0044);
        chk("t6_pend", 32'(dut.irq_pend), 32'd1);
        cyc(1, 0, 0, 0, 0, 1);
        async_reset();

        // Randomized traffic against the model
        r_iq = 0;
        for (int i = 0; i < 4000; i++) begin
            r_ex = ($urandom_range(0, 99) < 4);
            r_rv = ($urandom_range(0, 99) < 12);
            r_st = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 10) r_iq = ~r_iq;
            r_rp = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 19'd0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 99) < 3) r_rp = 32'h7FFF_FFF8;
            r_ep = $urandom;
            if ($urandom_range(0, 999) < 2) begin
                async_reset();
                r_iq = 0;
            end else begin
                cyc(r_st, r_rv, r_rp, r_ex, r_ep, r_iq);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
